// File: rtl/ant_link_pkg.sv
`timescale 1ns/1ps
// ant_link_pkg
// Shared definitions for the inter-cell ant-transfer link. The transmitter,
// the receiver (ant_link_rx) and the probe display all import this package,
// so that bit positions on the 9-bit neighbour bus and the link-state codes
// agree across the whole design.
package ant_link_pkg;

    // Bit positions on the 9-bit neighbour bus
    localparam int LINK_W       = 9;
    localparam int LINK_ACK     = 0;
    localparam int LINK_REQ     = 1;
    localparam int LINK_PAY_LSB = 2;
    localparam int LINK_PAY_MSB = 8;

    // Width of one ant payload
    localparam int ANT_W = 7;

    // Link-state codes shown on the probe display
    typedef enum logic [1:0] {
        LS_IDLE  = 2'd0,
        LS_ACK   = 2'd1,
        LS_STALL = 2'd2
    } link_state_e;

    // Extract the ant payload from a neighbour bus word
    function automatic logic [ANT_W-1:0] link_payload(input logic [LINK_W-1:0] bus);
        return bus[LINK_PAY_MSB:LINK_PAY_LSB];
    endfunction

endpackage

// File: rtl/ant_link_rx_if.sv
`timescale 1ns/1ps
// ant_link_rx_if
// Bundles the neighbour bus pair and the local valid/ready ant stream of
// one receive side.
//   inLink    neighbour -> rx bus (req on bit 1, payload on 8:2)
//   outLink   rx -> neighbour bus (ack on bit 0, rest zero)
//   antData   head-of-FIFO payload
//   antValid  FIFO non-empty
//   antReady  local cell consumes head entry
//   count     FIFO occupancy
//   linkState IDLE / ACK / STALL code for the probe display
// Modports: slave = the receiver, master = neighbour + local cell side.
interface ant_link_rx_if
    import ant_link_pkg::*;
#(
    parameter int CW = 3
) ();
    logic [LINK_W-1:0] inLink;
    logic [LINK_W-1:0] outLink;
    logic [ANT_W-1:0]  antData;
    logic              antValid;
    logic              antReady;
    logic [CW-1:0]     count;
    logic [1:0]        linkState;

    modport slave (
        input  inLink,
        input  antReady,
        output outLink,
        output antData,
        output antValid,
        output count,
        output linkState
    );

    modport master (
        output inLink,
        output antReady,
        input  outLink,
        input  antData,
        input  antValid,
        input  count,
        input  linkState
    );
endinterface

// File: rtl/ant_fifo.sv
`timescale 1ns/1ps
// ant_fifo
// DEPTH x W register FIFO holding received ants.
//   clk, rst_n  clock, async active-low reset (pointers and count only)
//   i_push      write i_data at the tail (ignored when full)
//   i_data      entry to write
//   i_pop       drop the head entry (ignored when empty)
//   o_data      head entry, combinational; meaningless when o_empty
//   o_full      count == DEPTH
//   o_empty     count == 0
//   o_count     occupancy 0..DEPTH
module ant_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = 3,
    parameter int W     = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Guarding here keeps count within 0..DEPTH whatever the caller does
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // Storage carries no reset; stale entries are unreachable once count=0
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/ant_link_rx.sv
`timescale 1ns/1ps
// ant_link_rx
// Receive end of the inter-cell ant link. Accepts one ant per four-phase
// req/ack pulse from the neighbour, buffers it in ant_fifo and presents it
// to the local cell as a valid/ready stream.
//   clk    system clock
//   rst_n  async active-low reset; drops ack at once and empties the FIFO
//   link   ant_link_rx_if.slave: inLink/outLink neighbour buses,
//          antData/antValid/antReady local stream, count, linkState
module ant_link_rx
    import ant_link_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    ant_link_rx_if.slave  link
);
    link_state_e r_state;
    logic        r_ack;

    logic             w_req;
    logic [ANT_W-1:0] w_payload;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count;
    logic             w_unused_bit;

    assign w_req        = link.inLink[LINK_REQ];
    assign w_payload    = link_payload(link.inLink);
    assign w_unused_bit = link.inLink[LINK_ACK];

    // Push only from IDLE or STALL: ACK waits for req to fall, so each req
    // pulse yields exactly one entry. Full is the registered count, so a
    // same-cycle pop on a full FIFO cannot open room for this push.
    assign w_push = w_req && !w_full && (r_state != LS_ACK);
    assign w_pop  = link.antReady && !w_empty;

    ant_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .W     (ANT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_payload),
        .i_pop   (w_pop),
        .o_data  (link.antData),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LS_IDLE;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                LS_IDLE: begin
                    if (w_req && !w_full) begin
                        r_state <= LS_ACK;
                        r_ack   <= 1'b1;
                    end else if (w_req) begin
                        r_state <= LS_STALL;
                    end
                end
                LS_STALL: begin
                    if (!w_req) begin
                        // Offer withdrawn by the neighbour
                        r_state <= LS_IDLE;
                    end else if (!w_full) begin
                        r_state <= LS_ACK;
                        r_ack   <= 1'b1;
                    end
                end
                LS_ACK: begin
                    if (!w_req) begin
                        r_state <= LS_IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= LS_IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    assign link.outLink   = {{(LINK_W-1){1'b0}}, r_ack};
    assign link.antValid  = !w_empty;
    assign link.count     = w_count;
    assign link.linkState = r_state;
endmodule

// File: tb/tb_ant_link_rx.sv
`timescale 1ns/1ps
module tb_ant_link_rx;
    import ant_link_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ant_link_rx_if #(.CW(CW)) bus ();

    ant_link_rx #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: a queue of buffered ants plus whether the neighbour
    // is currently acknowledged or being held off.
    logic [6:0] m_q[$];
    bit         m_ack;
    bit         m_stall;
    logic [6:0] popped[$];

    function automatic logic [14:0] exp_vec();
        logic [1:0] ls;
        ls = m_ack ? 2'd1 : (m_stall ? 2'd2 : 2'd0);
        return {8'd0, m_ack, ls, CW'(m_q.size()), (m_q.size() != 0)};
    endfunction

    function automatic logic [14:0] obs_vec();
        return {bus.outLink, bus.linkState, bus.count, bus.antValid};
    endfunction

    // Drive one cycle of stimulus, advance the model over the coming edge,
    // and return #1 after that edge.
    task automatic step(input bit req, input logic [6:0] pay, input bit ready);
        bit full, do_pop, do_push, new_ack;
        @(negedge clk);
        bus.inLink   = {pay, req, 1'($urandom_range(0, 1))};
        bus.antReady = ready;
        #1;
        if (bus.antValid && ready) popped.push_back(bus.antData);
        full    = (m_q.size() >= DEPTH);
        do_pop  = ready && (m_q.size() > 0);
        do_push = !m_ack && req && !full;
        new_ack = do_push ? 1'b1 : (req ? m_ack : 1'b0);
        m_stall = req && !new_ack;
        m_ack   = new_ack;
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(pay);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 8; i++) begin
            if (m_q.size() == 0 && !m_ack && !m_stall) break;
            step(1'b0, 7'd0, 1'b1);
        end
    endtask

    task automatic test_reset();
        bus.inLink   = '0;
        bus.antReady = 1'b0;
        m_q.delete();
        m_ack = 0; m_stall = 0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (obs_vec() !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), 15'd0);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(1'b0, 7'd0, 1'b0);
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_idle: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        step(1'b1, 7'h2A, 1'b0);
        vectors++;
        if (obs_vec() !== {8'd0, 1'b1, 2'd1, 3'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL single_accept: got %h expected %h", obs_vec(), {8'd0, 1'b1, 2'd1, 3'd1, 1'b1});
        end
        vectors++;
        if (bus.antData !== 7'h2A) begin
            miscompares++;
            $display("FAIL single_data: got %h expected %h", bus.antData, 7'h2A);
        end
        step(1'b0, 7'h00, 1'b0);
        vectors++;
        if (bus.outLink !== 9'd0 || bus.linkState !== 2'd0) begin
            miscompares++;
            $display("FAIL single_release: got outLink=%h state=%0d expected 000/0", bus.outLink, bus.linkState);
        end
        drain();
    endtask

    task automatic test_burst_stall();
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 7'(i), 1'b0);
            vectors++;
            if (obs_vec() !== exp_vec() || bus.outLink[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL burst_ack%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            step(1'b0, 7'd0, 1'b0);
        end
        vectors++;
        if (bus.count !== 3'd4) begin
            miscompares++;
            $display("FAIL burst_count: got %0d expected 4", bus.count);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 7'h05, 1'b0);
            vectors++;
            if (obs_vec() !== exp_vec() || bus.linkState !== 2'd2 || bus.outLink[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_stall_exit();
        vectors++;
        if (bus.antData !== 7'h01) begin
            miscompares++;
            $display("FAIL stall_head: got %h expected %h", bus.antData, 7'h01);
        end
        popped.delete();
        step(1'b1, 7'h05, 1'b1);
        vectors++;
        if (obs_vec() !== exp_vec() || bus.count !== 3'd3 || bus.linkState !== 2'd2) begin
            miscompares++;
            $display("FAIL stall_pop_edge: got %h expected %h", obs_vec(), exp_vec());
        end
        step(1'b1, 7'h05, 1'b0);
        vectors++;
        if (obs_vec() !== exp_vec() || bus.count !== 3'd4 || bus.outLink[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_exit: got %h expected %h", obs_vec(), exp_vec());
        end
        vectors++;
        if (popped.size() != 1 || popped[0] !== 7'h01) begin
            miscompares++;
            $display("FAIL stall_popped: got n=%0d first=%h expected n=1 first=01", popped.size(),
                     (popped.size() > 0) ? popped[0] : 7'h7F);
        end
        step(1'b0, 7'd0, 1'b0);
        drain();
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL stall_drain: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] sent[$];
        logic [6:0] p;
        popped.delete();
        for (int i = 0; i < 10; i++) begin
            p = 7'($urandom);
            sent.push_back(p);
            step(1'b1, p, 1'b1);
            vectors++;
            if (obs_vec() !== exp_vec() || bus.count > 3'd1) begin
                miscompares++;
                $display("FAIL stream_push%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            step(1'b0, 7'd0, 1'b1);
            vectors++;
            if (obs_vec() !== exp_vec() || bus.count > 3'd1) begin
                miscompares++;
                $display("FAIL stream_gap%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        drain();
        vectors++;
        if (popped.size() != 10) begin
            miscompares++;
            $display("FAIL stream_len: got %0d expected 10", popped.size());
        end
        for (int i = 0; i < 10 && i < popped.size(); i++) begin
            vectors++;
            if (popped[i] !== sent[i]) begin
                miscompares++;
                $display("FAIL stream_order%0d: got %h expected %h", i, popped[i], sent[i]);
            end
        end
    endtask

    task automatic test_hold_req();
        logic [6:0] p;
        p = 7'($urandom);
        step(1'b1, p, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, p, 1'b0);
            vectors++;
            if (bus.linkState !== 2'd1 || bus.count !== 3'd1 || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL hold_req%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        step(1'b0, 7'd0, 1'b0);
        drain();
    endtask

    task automatic test_reset_mid();
        step(1'b1, 7'h11, 1'b0);
        step(1'b0, 7'h00, 1'b0);
        step(1'b1, 7'h22, 1'b0);
        step(1'b0, 7'h00, 1'b0);
        step(1'b1, 7'h33, 1'b0);
        vectors++;
        if (bus.count !== 3'd3 || bus.outLink[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_pre: got count=%0d ack=%b expected 3/1", bus.count, bus.outLink[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        m_q.delete();
        m_ack = 0; m_stall = 0;
        vectors++;
        if (obs_vec() !== 15'd0) begin
            miscompares++;
            $display("FAIL rstmid_async: got %h expected %h", obs_vec(), 15'd0);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 7'h33, 1'b0);
            vectors++;
            if (obs_vec() !== exp_vec() || bus.count !== 3'd1) begin
                miscompares++;
                $display("FAIL rstmid_repush%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        step(1'b0, 7'd0, 1'b0);
        drain();
    endtask

    task automatic test_random();
        logic [6:0] p;
        bit r, rd;
        for (int i = 0; i < 120; i++) begin
            p  = 7'($urandom);
            r  = ($urandom_range(0, 99) < 60);
            rd = ($urandom_range(0, 99) < 35);
            step(r, p, rd);
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (m_q.size() > 0) begin
                vectors++;
                if (bus.antData !== m_q[0]) begin
                    miscompares++;
                    $display("FAIL random_data%0d: got %h expected %h", i, bus.antData, m_q[0]);
                end
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_stall();
        test_stall_exit();
        test_back_to_back();
        test_hold_req();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
